// File: rtl/soml_pkg.sv
// Shared types and constants for the SOML dot-product scheduler slice.
package soml_pkg;

  localparam int ADDR_W     = 2;
  localparam int DW_DEFAULT = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
  } res_tag_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/ygb_dot_sched_if.sv
// Datapath select/result bus plus the tagged result handshake of the scheduler.
interface ygb_dot_sched_if
  import soml_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);

  logic [ADDR_W-1:0] dp_addr_row;
  logic [ADDR_W-1:0] dp_addr_col;
  logic              dp_issue;
  logic [DW-1:0]     dp_result;
  logic [DW-1:0]     res_data;
  logic [ADDR_W-1:0] res_row;
  logic [ADDR_W-1:0] res_col;
  logic              res_valid;
  logic              res_ready;

  modport master (
    output dp_addr_row, dp_addr_col, dp_issue,
    output res_data, res_row, res_col, res_valid,
    input  dp_result, res_ready
  );

  modport slave (
    input  dp_addr_row, dp_addr_col, dp_issue,
    input  res_data, res_row, res_col, res_valid,
    output dp_result, res_ready
  );

endinterface

// File: rtl/soml_tag_fifo.sv
// Synchronous FIFO carrying {tag, data}; head is shown combinationally from the read pointer.
module soml_tag_fifo
  import soml_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = DW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  res_tag_t               push_tag,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output res_tag_t               head_tag,
  output logic [DW-1:0]          head_data,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  res_tag_t      tag_mem  [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  always_comb begin
    do_pop = pop && (count != '0);
  end

  // Storage is cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        tag_mem[wr_ptr]  <= push_tag;
        data_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!push && do_pop) begin
        count <= count - CW'(1);
      end
    end
  end

  assign head_tag  = tag_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign valid     = (count != '0);

  a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
    !(push && (count == CW'(DEPTH))));

endmodule

// File: rtl/ygb_dot_sched.sv
// Row-major (row, col) issue scheduler for the cmult/vadd dot-product datapath,
// with credit-limited issue, a LAT-deep tag pipeline and a tagged result FIFO.
module ygb_dot_sched
  import soml_pkg::*;
#(
  parameter int NROW       = 2,
  parameter int NCOL       = 2,
  parameter int LAT        = 4,
  parameter int DW         = DW_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  ygb_dot_sched_if.master bus
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW  = $clog2(LAT + FIFO_DEPTH + 1) + 1;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NROW - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(NCOL - 1);

  state_t            state;
  logic [ADDR_W-1:0] row_cnt;
  logic [ADDR_W-1:0] col_cnt;
  logic [CW-1:0]     inflight;
  logic [FCW-1:0]    fifo_count;
  logic [LAT-1:0]    pipe_vld;
  res_tag_t          pipe_tag [LAT];
  res_tag_t          head_tag;
  logic              credit;
  logic              issue_now;
  logic              pop;
  logic              drain_empty;

  // Inflight counts from the issue decision, so a result is always covered by
  // either inflight or fifo_count and the credit sum never under-reports.
  always_comb begin
    pop         = bus.res_valid && bus.res_ready;
    credit      = (inflight + CW'(fifo_count)) < CW'(FIFO_DEPTH);
    issue_now   = (state == RUN) && credit;
    drain_empty = (inflight == '0) &&
                  ((fifo_count == '0) || ((fifo_count == FCW'(1)) && pop));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      bus.dp_issue    <= 1'b0;
      bus.dp_addr_row <= '0;
      bus.dp_addr_col <= '0;
      row_cnt         <= '0;
      col_cnt         <= '0;
    end else begin
      done         <= 1'b0;
      bus.dp_issue <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            row_cnt <= '0;
            col_cnt <= '0;
          end
        end
        RUN: begin
          if (credit) begin
            bus.dp_issue    <= 1'b1;
            bus.dp_addr_row <= row_cnt;
            bus.dp_addr_col <= col_cnt;
            if (col_cnt == LAST_COL) begin
              col_cnt <= '0;
              if (row_cnt == LAST_ROW) begin
                state <= DRAIN;
              end else begin
                row_cnt <= row_cnt + ADDR_W'(1);
              end
            end else begin
              col_cnt <= col_cnt + ADDR_W'(1);
            end
          end
        end
        // Finishing on the edge that pops the last entry makes done line up
        // with the cycle right after the final result is consumed.
        DRAIN: begin
          if (drain_empty) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (issue_now && !pipe_vld[LAT-1]) begin
      inflight <= inflight + CW'(1);
    end else if (!issue_now && pipe_vld[LAT-1]) begin
      inflight <= inflight - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        pipe_tag[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= bus.dp_issue;
      pipe_tag[0] <= '{row: bus.dp_addr_row, col: bus.dp_addr_col};
      for (int unsigned i = 1; i < LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  soml_tag_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_vld[LAT-1]),
    .push_tag  (pipe_tag[LAT-1]),
    .push_data (bus.dp_result),
    .pop       (bus.res_ready),
    .head_tag  (head_tag),
    .head_data (bus.res_data),
    .valid     (bus.res_valid),
    .count     (fifo_count)
  );

  assign bus.res_row = head_tag.row;
  assign bus.res_col = head_tag.col;

endmodule

// File: tb/tb_ygb_dot_sched.sv
// Bench for ygb_dot_sched: three configurations, directed timelines plus randomized scoreboard sweeps.
module tb_ygb_dot_sched;

  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, start_b, start_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;

  ygb_dot_sched_if #(.DW(16)) bus_a ();
  ygb_dot_sched_if #(.DW(16)) bus_b ();
  ygb_dot_sched_if #(.DW(16)) bus_c ();

  ygb_dot_sched #(.NROW(2), .NCOL(2), .LAT(LAT), .DW(16), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .bus(bus_a));
  ygb_dot_sched #(.NROW(2), .NCOL(4), .LAT(LAT), .DW(16), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .bus(bus_b));
  ygb_dot_sched #(.NROW(1), .NCOL(1), .LAT(LAT), .DW(16), .FIFO_DEPTH(2)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c), .bus(bus_c));

  // Datapath model: value row*16+col appears LAT cycles after its issue; junk otherwise.
  function automatic logic [15:0] dp_val(input logic [1:0] r, input logic [1:0] c);
    return 16'(int'(r) * 16 + int'(c));
  endfunction

  logic [15:0] dpa [LAT];
  logic [15:0] dpb [LAT];
  logic [15:0] dpc [LAT];

  always @(posedge clk) begin
    dpa[0] <= bus_a.dp_issue ? dp_val(bus_a.dp_addr_row, bus_a.dp_addr_col) : 16'($urandom);
    dpb[0] <= bus_b.dp_issue ? dp_val(bus_b.dp_addr_row, bus_b.dp_addr_col) : 16'($urandom);
    dpc[0] <= bus_c.dp_issue ? dp_val(bus_c.dp_addr_row, bus_c.dp_addr_col) : 16'($urandom);
    for (int i = 1; i < LAT; i++) begin
      dpa[i] <= dpa[i-1];
      dpb[i] <= dpb[i-1];
      dpc[i] <= dpc[i-1];
    end
  end

  assign bus_a.dp_result = dpa[LAT-1];
  assign bus_b.dp_result = dpb[LAT-1];
  assign bus_c.dp_result = dpc[LAT-1];

  int checks = 0;
  int errors = 0;

  logic        s_issue, s_valid, s_busy, s_done;
  logic [1:0]  s_row, s_col, s_rrow, s_rcol;
  logic [15:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic sample(input int w);
    case (w)
      0: begin
        s_issue = bus_a.dp_issue;  s_row = bus_a.dp_addr_row; s_col = bus_a.dp_addr_col;
        s_valid = bus_a.res_valid; s_data = bus_a.res_data;   s_rrow = bus_a.res_row;
        s_rcol = bus_a.res_col;    s_busy = busy_a;           s_done = done_a;
      end
      1: begin
        s_issue = bus_b.dp_issue;  s_row = bus_b.dp_addr_row; s_col = bus_b.dp_addr_col;
        s_valid = bus_b.res_valid; s_data = bus_b.res_data;   s_rrow = bus_b.res_row;
        s_rcol = bus_b.res_col;    s_busy = busy_b;           s_done = done_b;
      end
      default: begin
        s_issue = bus_c.dp_issue;  s_row = bus_c.dp_addr_row; s_col = bus_c.dp_addr_col;
        s_valid = bus_c.res_valid; s_data = bus_c.res_data;   s_rrow = bus_c.res_row;
        s_rcol = bus_c.res_col;    s_busy = busy_c;           s_done = done_c;
      end
    endcase
  endtask

  task automatic drive(input int w, input logic st, input logic rdy);
    case (w)
      0:       begin start_a = st; bus_a.res_ready = rdy; end
      1:       begin start_b = st; bus_b.res_ready = rdy; end
      default: begin start_c = st; bus_c.res_ready = rdy; end
    endcase
  endtask

  task automatic chk_zero(input int w, input string tag);
    sample(w);
    chk({tag, "_busy"},  32'(s_busy),  32'(0));
    chk({tag, "_done"},  32'(s_done),  32'(0));
    chk({tag, "_issue"}, 32'(s_issue), 32'(0));
    chk({tag, "_addr"},  32'({s_row, s_col}), 32'(0));
    chk({tag, "_valid"}, 32'(s_valid), 32'(0));
    chk({tag, "_head"},  32'({s_data, s_rrow, s_rcol}), 32'(0));
  endtask

  // Unstalled sweep timeline: issue k at cycle 2+k, result k visible at 3+LAT+k,
  // done one cycle after the final pop.
  task automatic timeline(input int w, input int nrow, input int ncol);
    int n;
    int done_cyc;
    int k;
    logic exp_issue;
    logic exp_valid;
    n = nrow * ncol;
    done_cyc = 2 + (n - 1) + LAT + 2;
    for (int c = 0; c <= done_cyc + 2; c++) begin
      step();
      sample(w);
      exp_issue = (c >= 2) && (c < 2 + n);
      exp_valid = (c >= 3 + LAT) && (c < 3 + LAT + n);
      chk("tl_issue", 32'(s_issue), 32'(exp_issue));
      if (exp_issue) begin
        k = c - 2;
        chk("tl_addr", 32'({s_row, s_col}), 32'({2'(k / ncol), 2'(k % ncol)}));
      end
      chk("tl_valid", 32'(s_valid), 32'(exp_valid));
      if (exp_valid) begin
        k = c - 3 - LAT;
        chk("tl_data", 32'(s_data), 32'(16'((k / ncol) * 16 + (k % ncol))));
        chk("tl_tag", 32'({s_rrow, s_rcol}), 32'({2'(k / ncol), 2'(k % ncol)}));
      end
      chk("tl_busy", 32'(s_busy), 32'((c >= 1) && (c < done_cyc)));
      chk("tl_done", 32'(s_done), 32'(c == done_cyc));
      drive(w, c == 0, 1'b1);
    end
  endtask

  // mode: 0 ready=1, 1 random, 2 alternating, 3 held low for 30 cycles.
  task automatic sweep(input int w, input int nrow, input int ncol, input int fdepth,
                       input int mode, input int restart_at);
    int n;
    int issued;
    int popped;
    int dones;
    int after_done;
    logic rdy;
    logic prev_valid;
    logic prev_rdy;
    logic [15:0] prev_data;
    logic [3:0] prev_tag;
    logic [3:0] last_addr;
    n = nrow * ncol;
    issued = 0; popped = 0; dones = 0; after_done = -1;
    prev_valid = 1'b0; prev_rdy = 1'b1; prev_data = '0; prev_tag = '0; last_addr = '0;
    for (int c = 0; c < 400 && after_done < 3; c++) begin
      step();
      sample(w);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        2:       rdy = 1'(c % 2);
        default: rdy = (c >= 30);
      endcase
      if (s_issue) begin
        chk("sw_issue_extra", 32'(issued < n), 32'(1));
        chk("sw_issue_addr", 32'({s_row, s_col}), 32'({2'(issued / ncol), 2'(issued % ncol)}));
        issued++;
        last_addr = {s_row, s_col};
      end else if (issued > 0 && issued < n) begin
        chk("sw_stall_hold", 32'({s_row, s_col}), 32'(last_addr));
      end
      chk("sw_credit", 32'((issued - popped) <= fdepth), 32'(1));
      if (prev_valid && !prev_rdy) begin
        chk("sw_hold_valid", 32'(s_valid), 32'(1));
        chk("sw_hold_data", 32'({s_data, s_rrow, s_rcol}), 32'({prev_data, prev_tag}));
      end
      if (mode == 3 && c == 30) begin
        chk("bp_issued", 32'(issued), 32'(fdepth));
        chk("bp_full_valid", 32'(s_valid), 32'(1));
      end
      if (s_valid && rdy) begin
        chk("sw_pop_extra", 32'(popped < n), 32'(1));
        chk("sw_data", 32'(s_data), 32'(16'((popped / ncol) * 16 + (popped % ncol))));
        chk("sw_tag", 32'({s_rrow, s_rcol}), 32'({2'(popped / ncol), 2'(popped % ncol)}));
        popped++;
      end
      chk("sw_busy", 32'(s_busy), 32'((c >= 1) && (dones == 0) && !s_done));
      if (s_done) begin
        dones++;
        chk("sw_done_after_pops", 32'(popped), 32'(n));
        if (after_done < 0) after_done = 0;
      end
      if (after_done >= 0) after_done++;
      drive(w, (c == 0) || (c == restart_at), rdy);
      prev_valid = s_valid;
      prev_rdy   = rdy;
      prev_data  = s_data;
      prev_tag   = {s_rrow, s_rcol};
    end
    chk("sw_issued_total", 32'(issued), 32'(n));
    chk("sw_popped_total", 32'(popped), 32'(n));
    chk("sw_done_count", 32'(dones), 32'(1));
    drive(w, 1'b0, 1'b1);
  endtask

  initial begin
    int issued;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    bus_a.res_ready = 1'b1; bus_b.res_ready = 1'b1; bus_c.res_ready = 1'b1;
    step();
    chk_zero(0, "rst_a");
    chk_zero(1, "rst_b");
    chk_zero(2, "rst_c");
    rst = 1'b0;
    step();

    timeline(0, 2, 2);
    sweep(1, 2, 4, 4, 3, -1);
    sweep(0, 2, 2, 4, 2, -1);
    sweep(0, 2, 2, 4, 1, -1);
    sweep(0, 2, 2, 4, 1, -1);
    sweep(0, 2, 2, 4, 0, 4);

    issued = 0;
    for (int c = 0; c < 20 && issued < 3; c++) begin
      step();
      sample(0);
      if (s_issue) issued++;
      drive(0, c == 0, 1'b1);
    end
    chk("rst_mid_issued", 32'(issued), 32'(3));
    #2 rst = 1'b1;
    #1 chk_zero(0, "rst_mid");
    step();
    step();
    rst = 1'b0;
    step();
    sweep(0, 2, 2, 4, 1, -1);

    timeline(2, 1, 1);
    sweep(2, 1, 1, 2, 1, -1);
    sweep(1, 2, 4, 4, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ygb_dot_sched.md
Name: ygb_dot_sched

Overview:
- Scheduler for the Y-row × column complex dot-product datapath in the SOML decoder. The datapath is four cmult lanes feeding a vadd tree.
- On `start` it walks every (row, col) address pair and drives the datapath's row/column selects.
- It tracks the fixed multiply/add pipeline latency and captures each real-part result.
- Captured results are buffered in a small tagged FIFO, drained by a downstream consumer with a valid/ready handshake.

Parameters:
- NROW, 2, number of Y rows to evaluate (1..4).
- NCOL, 2, number of columns per row (1..4).
- LAT, 4, cycles from `dp_issue` to a valid `dp_result` (cmult + adder tree).
- DW, 16, result width (signed fixed point).
- FIFO_DEPTH, 4, result buffer entries (power of two, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to run one full NROW×NCOL sweep.
- busy  out  1  high from the cycle after an accepted start until the done pulse.
- done  out  1  one-cycle pulse when the final result has been popped.
- dp_addr_row  out  2  row select to datapath.
- dp_addr_col  out  2  column select to datapath.
- dp_issue  out  1  qualifies dp_addr_* this cycle.
- dp_result  in  DW  datapath real output, sampled LAT cycles after the matching issue.
- res_data  out  DW  FIFO head data.
- res_row  out  2  row tag of head.
- res_col  out  2  column tag of head.
- res_valid  out  1  FIFO not empty.
- res_ready  in  1  consumer accepts head when res_valid&res_ready.

Behaviour:
- Reset values:
  - busy, done, dp_issue, res_valid: 0.
  - dp_addr_row, dp_addr_col, res_data, res_row, res_col: 0.
  - FSM in IDLE; FIFO, counters and tag pipeline cleared.
- Reset asserted mid-sweep aborts immediately. In-flight datapath results are ignored because the tag pipeline is cleared.
- FSM states:
  - IDLE: start=1 → RUN; the row/col counters load 0. start in any other state is ignored.
  - RUN: issue one pair per cycle when credit allows. The issue of (NROW-1, NCOL-1) → DRAIN.
  - DRAIN: no issues; wait until in-flight count = 0 and FIFO empty → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE. A start arriving in DONE is ignored.
- Issue order is row-major: col increments first; on col=NCOL-1, col wraps to 0 and row increments.
- All outputs are registered. A pair first appears with dp_issue=1 in the cycle after the FSM enters RUN.
- Credit rule: issue only if inflight + fifo_count < FIFO_DEPTH.
  - Counts are evaluated from current registers.
  - A pop in the same cycle does not grant credit until the next cycle.
  - Result: the FIFO never overflows and no result is dropped.
- Stall: while credit is zero, dp_issue=0 and the addresses hold their last values.
- Tag pipeline:
  - LAT-deep shift register of {valid,row,col}, loaded with {dp_issue, addr} each cycle.
  - When the tail valid=1, dp_result is pushed with its tags.
  - Latency from issue to res_valid is LAT+1 cycles (push edge, then visible).
- FIFO behaviour:
  - Push and pop in the same cycle: count unchanged, both performed.
  - Pop when empty: ignored.
  - Push when full: cannot occur by the credit rule. Assert it in simulation.
  - Pointers wrap modulo FIFO_DEPTH.
- res_data/res_row/res_col stay stable while res_valid=1 and res_ready=0.
- inflight counter:
  - +1 on issue, −1 on tail-valid.
  - Both in the same cycle: unchanged.
  - Range 0..LAT.
- Data is passed unmodified; no arithmetic on dp_result.

Decomposition:
- Shared package `soml_pkg`:
  - ADDR_W=2, DW default.
  - Typedef of the result tag struct {row, col}.
  - FSM state enum {IDLE, RUN, DRAIN, DONE}.
- One natural sub-module: `soml_tag_fifo`, a parameterised sync FIFO carrying {tag, data} with count output.
- Tag shift register and FSM stay in the top.

Test Plan:
- Basic sweep (defaults, LAT=4, res_ready=1). Bench models dp_result = row*16+col delayed LAT. Pulse start at cycle 0.
  - Issues (0,0),(0,1),(1,0),(1,1) at cycles 2..5.
  - res_valid with data 0x0000,0x0001,0x0010,0x0011 at cycles 7..10.
  - done pulse at cycle 11, busy low at 11.
- Backpressure (NCOL=4, res_ready=0): exactly 4 issues (0,0)..(0,3), then dp_issue stays 0; FIFO holds 4 entries. Raise res_ready, then:
  - Remaining 4 pairs issue, one per credit.
  - All 8 results arrive in order with correct tags.
  - done fires once after the 8th pop.
- Ready toggling (res_ready alternating 1/0): head data stable while stalled; no duplicate or missing entries. Simulation assertion checks no push-when-full.
- start while busy (pulse start at cycle 4 of a sweep): ignored; exactly NROW*NCOL results and one done.
- Async reset mid-sweep (assert rst between clock edges after 3 results are in flight):
  - All outputs 0 immediately.
  - After release, a new start produces a clean full sweep with no stale results.
- Edge config (NROW=1, NCOL=1, FIFO_DEPTH=2): single issue (0,0), one result, done at issue+LAT+2.
